// File: rtl/branch_cond_unit.sv
// ---------------------------------------------------------------------------
// branch_cond_unit
// Evaluates a 3-bit branch condition from ir[CC_LSB+2:CC_LSB] against the
// operand on bus_in and holds the registered branch-taken flag until the
// next evaluation or a flush.
//
// PIPE_EN = 0 : the result loads on the same edge that samples con_in.
// PIPE_EN = 1 : the zero and sign flags and the condition code are
//               registered first (EVAL), and the result loads one edge later.
//
// Optional feature macro: BRANCH_COND_STATS_EN
//   When this macro is defined, the unit adds eval_count and taken_count.
//   These are saturating 16-bit counters of completed evaluations and of
//   completed evaluations whose result was 1. Flushing does not clear them.
// ---------------------------------------------------------------------------
module branch_cond_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CC_LSB     = 19,
    parameter int PIPE_EN    = 0
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic [31:0]           ir,
    input  logic                  con_in,
    input  logic                  con_flush,
    output logic                  con_out,
    output logic                  con_valid,
    output logic                  busy
`ifdef BRANCH_COND_STATS_EN
    ,
    output logic [15:0]           eval_count,
    output logic [15:0]           taken_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t     state_reg;
    logic       con_out_reg;
    logic       con_valid_reg;
    logic       busy_reg;

    // Compare stage registers; only loaded when PIPE_EN is set.
    logic       zero_reg;
    logic       sign_reg;
    logic [2:0] cc_reg;

    logic       zero_now;
    logic       sign_now;
    logic [2:0] cc_now;
    logic       result_now;
    logic       result_pipe;
    logic       eval_done;
    logic       done_result;

    // Condition decode shared by the direct and the pipelined paths.
    function automatic logic cond_eval(input logic zero,
                                       input logic sign,
                                       input logic [2:0] cc);
        logic taken;
        taken = 1'b0;
        case (cc)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b010:  taken = !sign;
            3'b011:  taken = sign;
            3'b100:  taken = !sign && !zero;
            3'b101:  taken = sign || zero;
            3'b110:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Operand flags and condition code as seen on the current edge.
    always_comb begin
        zero_now    = (bus_in == '0);
        sign_now    = bus_in[DATA_WIDTH-1];
        cc_now      = ir[CC_LSB+2:CC_LSB];
        result_now  = cond_eval(zero_now, sign_now, cc_now);
        result_pipe = cond_eval(zero_reg, sign_reg, cc_reg);
    end

    // Detect an evaluation that completes on this edge.
    // A flush on the same edge cancels the evaluation.
    always_comb begin
        eval_done   = 1'b0;
        done_result = 1'b0;
        if (!con_flush) begin
            if (state_reg == ST_EVAL) begin
                eval_done   = 1'b1;
                done_result = result_pipe;
            end else if (con_in && (PIPE_EN == 0)) begin
                eval_done   = 1'b1;
                done_result = result_now;
            end
        end
    end

    // Control FSM with registered outputs.
    // A flush overrides everything else on its edge.
    // While in EVAL, the FSM ignores con_in.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg     <= ST_IDLE;
            con_out_reg   <= 1'b0;
            con_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            zero_reg      <= 1'b0;
            sign_reg      <= 1'b0;
            cc_reg        <= 3'b000;
        end else if (con_flush) begin
            state_reg     <= ST_IDLE;
            con_out_reg   <= 1'b0;
            con_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_EVAL: begin
                    con_out_reg   <= result_pipe;
                    con_valid_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                    state_reg     <= ST_HOLD;
                end
                default: begin
                    if (con_in) begin
                        if (PIPE_EN != 0) begin
                            // con_out keeps its old value until the stage completes.
                            zero_reg  <= zero_now;
                            sign_reg  <= sign_now;
                            cc_reg    <= cc_now;
                            busy_reg  <= 1'b1;
                            state_reg <= ST_EVAL;
                        end else begin
                            con_out_reg   <= result_now;
                            con_valid_reg <= 1'b1;
                            state_reg     <= ST_HOLD;
                        end
                    end
                end
            endcase
        end
    end

    assign con_out   = con_out_reg;
    assign con_valid = con_valid_reg;
    assign busy      = busy_reg;

    // Only the condition field of ir is consumed.
    logic unused_ir;
    assign unused_ir = ^ir;

`ifdef BRANCH_COND_STATS_EN
    // Bit 0 counts every completed evaluation.
    // Bit 1 counts only the evaluations that were taken.
    logic [1:0] stat_inc;
    assign stat_inc = {eval_done & done_result, eval_done};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_stat
            logic [15:0] cnt_reg;

            // Saturating event counter; it is cleared only by reset.
            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    cnt_reg <= 16'h0000;
                end else if (stat_inc[gi] && (cnt_reg != 16'hFFFF)) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
        end
    endgenerate

    assign eval_count  = gen_stat[0].cnt_reg;
    assign taken_count = gen_stat[1].cnt_reg;
`else
    logic unused_stats;
    assign unused_stats = eval_done ^ done_result;
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// ---------------------------------------------------------------------------
// Testbench for branch_cond_unit.
// dut0 instantiates the unit with PIPE_EN=0 and dut1 with PIPE_EN=1.
// Both instances share clk, clr, bus_in and ir.
// Each instance has its own con_in and con_flush.
// The bench drives inputs and samples outputs 1 time unit after each
// rising edge of clk.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_cond_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] bus_in = 32'h0;
    logic [31:0] ir = 32'h0;
    logic        con_in0 = 1'b0, con_flush0 = 1'b0;
    logic        con_in1 = 1'b0, con_flush1 = 1'b0;
    logic        con_out0, con_valid0, busy0;
    logic        con_out1, con_valid1, busy1;
`ifdef BRANCH_COND_STATS_EN
    logic [15:0] eval_count0, taken_count0, eval_count1, taken_count1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_cond_unit #(.DATA_WIDTH(32), .CC_LSB(19), .PIPE_EN(0)) dut0 (
        .clk       (clk),
        .clr       (clr),
        .bus_in    (bus_in),
        .ir        (ir),
        .con_in    (con_in0),
        .con_flush (con_flush0),
        .con_out   (con_out0),
        .con_valid (con_valid0),
        .busy      (busy0)
`ifdef BRANCH_COND_STATS_EN
        ,
        .eval_count  (eval_count0),
        .taken_count (taken_count0)
`endif
    );

    branch_cond_unit #(.DATA_WIDTH(32), .CC_LSB(19), .PIPE_EN(1)) dut1 (
        .clk       (clk),
        .clr       (clr),
        .bus_in    (bus_in),
        .ir        (ir),
        .con_in    (con_in1),
        .con_flush (con_flush1),
        .con_out   (con_out1),
        .con_valid (con_valid1),
        .busy      (busy1)
`ifdef BRANCH_COND_STATS_EN
        ,
        .eval_count  (eval_count1),
        .taken_count (taken_count1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Place cc in ir[21:19] and fill the other bits of ir with random data.
    task automatic set_op(input logic [31:0] b, input logic [2:0] cc);
        logic [31:0] r;
        r      = $urandom();
        bus_in = b;
        ir     = (r & ~(32'h7 << 19)) | ({29'd0, cc} << 19);
    endtask

    typedef struct {
        logic [31:0] b;
        logic [2:0]  cc;
        logic        exp;
    } vec_t;

    vec_t vecs [14] = '{
        '{32'h80000000, 3'd3, 1'b1},
        '{32'h80000000, 3'd4, 1'b0},
        '{32'h80000000, 3'd5, 1'b1},
        '{32'h00000007, 3'd4, 1'b1},
        '{32'h00000000, 3'd4, 1'b0},
        '{32'h00000000, 3'd5, 1'b1},
        '{32'h00000007, 3'd5, 1'b0},
        '{32'h00000000, 3'd2, 1'b1},
        '{32'h80000000, 3'd2, 1'b0},
        '{32'h00000001, 3'd1, 1'b1},
        '{32'h00000000, 3'd1, 1'b0},
        '{32'h12345678, 3'd6, 1'b1},
        '{32'hFFFFFFFF, 3'd7, 1'b0},
        '{32'h00000000, 3'd7, 1'b0}
    };

    initial begin
        // Reset state
        #12;
        check("rst_out0",   {31'd0, con_out0},   32'd0);
        check("rst_valid0", {31'd0, con_valid0}, 32'd0);
        check("rst_busy0",  {31'd0, busy0},      32'd0);
        check("rst_out1",   {31'd0, con_out1},   32'd0);
        check("rst_valid1", {31'd0, con_valid1}, 32'd0);
        check("rst_busy1",  {31'd0, busy1},      32'd0);
        #1 clr = 1'b1;
        tick();

        // PIPE_EN=0: the result for a zero operand appears one edge after con_in.
        set_op(32'd0, 3'd0);
        con_in0 = 1'b1;
        tick();
        con_in0 = 1'b0;
        $display("p0 bus=%h cc=0 -> out=%0b valid=%0b", bus_in, con_out0, con_valid0);
        check("zero_out",   {31'd0, con_out0},   32'd1);
        check("zero_valid", {31'd0, con_valid0}, 32'd1);
        check("zero_busy0", {31'd0, busy0},      32'd0);

        // HOLD must stay stable while the operand changes.
        set_op(32'd5, 3'd1);
        tick();
        tick();
        check("hold_out",   {31'd0, con_out0},   32'd1);
        check("hold_valid", {31'd0, con_valid0}, 32'd1);

        // A nonzero operand with cc=000 is not taken.
        set_op(32'd5, 3'd0);
        con_in0 = 1'b1;
        tick();
        con_in0 = 1'b0;
        $display("p0 bus=%h cc=0 -> out=%0b", bus_in, con_out0);
        check("five_out", {31'd0, con_out0}, 32'd0);

        // Run the directed condition table through PIPE_EN=0.
        foreach (vecs[i]) begin
            set_op(vecs[i].b, vecs[i].cc);
            con_in0 = 1'b1;
            tick();
            con_in0 = 1'b0;
            $display("p0 vec%0d bus=%h cc=%0d -> out=%0b exp=%0b",
                     i, vecs[i].b, vecs[i].cc, con_out0, vecs[i].exp);
            check($sformatf("vec%0d_out", i), {31'd0, con_out0}, {31'd0, vecs[i].exp});
            check($sformatf("vec%0d_valid", i), {31'd0, con_valid0}, 32'd1);
        end

        // Flush and con_in on the same edge: the flush wins and the unit returns to IDLE.
        set_op(32'd0, 3'd6);
        con_in0 = 1'b1;
        tick();
        check("pre_flush_out", {31'd0, con_out0}, 32'd1);
        con_flush0 = 1'b1;
        tick();
        con_in0    = 1'b0;
        con_flush0 = 1'b0;
        $display("p0 flush+con_in -> out=%0b valid=%0b", con_out0, con_valid0);
        check("flush_out",   {31'd0, con_out0},   32'd0);
        check("flush_valid", {31'd0, con_valid0}, 32'd0);
        tick();
        check("idle_valid", {31'd0, con_valid0}, 32'd0);

        // PIPE_EN=1: busy is set after edge N and the result appears after edge N+1.
        // A second con_in at N+1 carries an operand that would give 0.
        // That strobe must be ignored.
        set_op(32'd0, 3'd0);
        con_in1 = 1'b1;
        tick();
        $display("p1 edgeN -> busy=%0b valid=%0b", busy1, con_valid1);
        check("p1_busy_n",  {31'd0, busy1},      32'd1);
        check("p1_valid_n", {31'd0, con_valid1}, 32'd0);
        check("p1_out_n",   {31'd0, con_out1},   32'd0);
        set_op(32'd5, 3'd0);
        tick();
        con_in1 = 1'b0;
        $display("p1 edgeN+1 -> out=%0b valid=%0b busy=%0b", con_out1, con_valid1, busy1);
        check("p1_out_n1",   {31'd0, con_out1},   32'd1);
        check("p1_valid_n1", {31'd0, con_valid1}, 32'd1);
        check("p1_busy_n1",  {31'd0, busy1},      32'd0);
        tick();
        check("p1_ignored_busy", {31'd0, busy1},    32'd0);
        check("p1_ignored_out",  {31'd0, con_out1}, 32'd1);

        // Re-evaluate from HOLD: the old result stays visible while EVAL is in progress.
        set_op(32'h80000000, 3'd4);
        con_in1 = 1'b1;
        tick();
        con_in1 = 1'b0;
        check("p1_re_busy",  {31'd0, busy1},      32'd1);
        check("p1_re_old",   {31'd0, con_out1},   32'd1);
        check("p1_re_valid", {31'd0, con_valid1}, 32'd1);
        tick();
        $display("p1 re-eval -> out=%0b", con_out1);
        check("p1_re_new", {31'd0, con_out1}, 32'd0);

        // A flush during EVAL discards the in-flight result.
        set_op(32'd0, 3'd0);
        con_in1 = 1'b1;
        tick();
        con_in1    = 1'b0;
        con_flush1 = 1'b1;
        tick();
        con_flush1 = 1'b0;
        $display("p1 flush in EVAL -> out=%0b valid=%0b busy=%0b", con_out1, con_valid1, busy1);
        check("p1_fl_out",   {31'd0, con_out1},   32'd0);
        check("p1_fl_valid", {31'd0, con_valid1}, 32'd0);
        check("p1_fl_busy",  {31'd0, busy1},      32'd0);
        tick();
        check("p1_fl_idle", {31'd0, con_valid1}, 32'd0);

        // Drive clr low during EVAL, between clock edges.
        // dut0 evaluates on the same edge so that it also holds a 1 when reset arrives.
        set_op(32'd0, 3'd6);
        con_in0 = 1'b1;
        con_in1 = 1'b1;
        tick();
        con_in0 = 1'b0;
        con_in1 = 1'b0;
        check("ar_pre_busy1", {31'd0, busy1},    32'd1);
        check("ar_pre_out0",  {31'd0, con_out0}, 32'd1);
        #2 clr = 1'b0;
        #1;
        $display("async reset -> out0=%0b out1=%0b busy1=%0b", con_out0, con_out1, busy1);
        check("ar_out0",   {31'd0, con_out0},   32'd0);
        check("ar_valid0", {31'd0, con_valid0}, 32'd0);
        check("ar_busy1",  {31'd0, busy1},      32'd0);
        check("ar_out1",   {31'd0, con_out1},   32'd0);
        #2 clr = 1'b1;
        tick();
        tick();
        check("ar_post_out1",   {31'd0, con_out1},   32'd0);
        check("ar_post_valid1", {31'd0, con_valid1}, 32'd0);
        check("ar_post_busy1",  {31'd0, busy1},      32'd0);

`ifdef BRANCH_COND_STATS_EN
        // Statistics counters: check a small known count, then saturation.
        clr = 1'b0;
        #3 clr = 1'b1;
        tick();
        con_in0 = 1'b1;
        set_op(32'd0, 3'd6);
        tick();
        set_op(32'd0, 3'd7);
        tick();
        set_op(32'd0, 3'd0);
        tick();
        con_in0 = 1'b0;
        tick();
        check("st_eval3",  {16'd0, eval_count0},  32'd3);
        check("st_taken2", {16'd0, taken_count0}, 32'd2);
        check("st_eval1",  {16'd0, eval_count1},  32'd0);
        set_op(32'd0, 3'd6);
        con_in0 = 1'b1;
        repeat (70000) @(posedge clk);
        #1 con_in0 = 1'b0;
        $display("stats -> eval=%h taken=%h", eval_count0, taken_count0);
        check("st_eval_sat",  {16'd0, eval_count0},  32'h0000FFFF);
        check("st_taken_sat", {16'd0, taken_count0}, 32'h0000FFFF);
        con_flush0 = 1'b1;
        tick();
        con_flush0 = 1'b0;
        check("st_flush_keep", {16'd0, eval_count0}, 32'h0000FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_cond_unit.md
BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of bus_in.
REQ-002 SHALL have parameter CC_LSB, default 19: bit position of the 3-bit condition field ir[CC_LSB+2:CC_LSB].
REQ-003 SHALL have parameter PIPE_EN, default 0: 0 gives a 1-cycle evaluation; 1 adds a compare register stage, giving a 2-cycle evaluation.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port clr, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port bus_in, input, DATA_WIDTH: operand register value under test.
REQ-007 SHALL have port ir, input, 32: instruction register.
REQ-008 SHALL have port con_in, input, 1: synchronous evaluate strobe, sampled high on a clk edge.
REQ-009 SHALL have port con_flush, input, 1: synchronous clear of the held result.
REQ-010 SHALL have port con_out, output, 1: registered branch-taken flag.
REQ-011 SHALL have port con_valid, output, 1: con_out holds a result not yet flushed.
REQ-012 SHALL have port busy, output, 1: an evaluation is in flight (PIPE_EN=1 only; otherwise tied 0).

Function
REQ-013 SHALL decode the condition field as: 000 zero; 001 nonzero; 010 non-negative (MSB=0); 011 negative (MSB=1); 100 positive (MSB=0 and nonzero); 101 non-positive (MSB=1 or zero); 110 always; 111 never.
REQ-014 SHALL treat bus_in as signed two's complement, using MSB bit DATA_WIDTH-1.
REQ-015 SHALL implement an FSM with states IDLE, EVAL (PIPE_EN=1 only) and HOLD.
REQ-016 SHALL, with PIPE_EN=0, on con_in=1 at edge N, load con_out from the bus_in/ir sampled at edge N, set con_valid=1 and enter HOLD.
REQ-017 SHALL, with PIPE_EN=1, on con_in=1 at edge N, register the zero flag, sign flag and condition code, enter EVAL with busy=1; at edge N+1, load con_out, set con_valid=1, clear busy and enter HOLD.
REQ-018 SHALL, in HOLD, keep con_out and con_valid stable until the next con_in or con_flush.
REQ-019 SHALL, on con_in in HOLD, re-evaluate with the same latency as REQ-016/REQ-017; con_out keeps its old value until the new result loads.
REQ-020 SHALL ignore con_in while in EVAL; the in-flight evaluation completes unchanged.
REQ-021 SHALL, on con_flush=1, clear con_out, con_valid and busy, and return to IDLE on that edge.
REQ-022 SHALL give con_flush priority over con_in and over EVAL completion when they coincide on the same edge.
REQ-023 SHALL change no state when neither con_in nor con_flush is asserted, except the EVAL to HOLD advance.

Reset
REQ-024 SHALL, while clr=0, asynchronously force state IDLE, con_out=0, con_valid=0 and busy=0, and clear the pipeline registers and statistics counters.
REQ-025 SHALL discard an evaluation interrupted by reset; the first clk edge after clr rises behaves as IDLE.

Configuration
REQ-026 SHALL, when macro BRANCH_COND_STATS_EN is defined, add outputs eval_count[15:0] and taken_count[15:0], counting completed evaluations and those with result 1, each saturating at 16'hFFFF; con_flush does not clear them.
REQ-027 SHALL, when BRANCH_COND_STATS_EN is undefined, omit these ports and counters; all other behaviour is identical.

Verification
REQ-028 SHALL cover: PIPE_EN=0, bus_in=0, cc=000, con_in pulse -> con_out=1 and con_valid=1 one cycle later; then bus_in=5, cc=000, con_in -> con_out=0.
REQ-029 SHALL cover: bus_in=32'h80000000 with cc=011, 100 and 101 -> con_out=1, 0, 1 respectively; bus_in=7 with cc=100 -> 1; any bus_in with cc=110 -> 1 and cc=111 -> 0.
REQ-030 SHALL cover: PIPE_EN=1, con_in at edge N -> busy=1 after edge N, con_out valid after N+1; a second con_in at N+1 is ignored.
REQ-031 SHALL cover: con_in and con_flush on the same edge -> con_out=0, con_valid=0, state IDLE.
REQ-032 SHALL cover: clr pulled low mid-EVAL, asynchronous to clk -> outputs 0 immediately; no result appears after release.
REQ-033 SHALL cover: BRANCH_COND_STATS_EN defined, 70000 taken evaluations -> eval_count=taken_count=16'hFFFF (saturated).
